// File: rtl/ov5640_init_seq_if.sv
// I2C write-master handshake between the init sequencer and the i2c block.
interface ov5640_init_seq_if;
    logic [23:0] i2c_send_dat;
    logic        i2c_sendit;
    logic        i2c_done;
    logic        i2c_ack;

    // Sequencer side: drives the write request, observes i2c status.
    modport master (
        output i2c_send_dat,
        output i2c_sendit,
        input  i2c_done,
        input  i2c_ack
    );

    // i2c block side.
    modport slave (
        input  i2c_send_dat,
        input  i2c_sendit,
        output i2c_done,
        output i2c_ack
    );
endinterface

// File: rtl/ov5640_init_seq.sv
// OV5640 power-up register loader: walks a table of {reg_addr, reg_data}
// entries, issues one i2c write per entry, honours 0xFFFF millisecond delay
// entries, retries NACKed/timed-out writes and reports DONE or FAIL.
module ov5640_init_seq #(
    parameter int NUM_ENTRIES    = 8,
    parameter int GAP_CYCLES     = 125,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 8191,
    parameter int MS_CYCLES      = 25000,
    // Entry i occupies bits [24*i +: 24]; entry 0 is the rightmost field.
    parameter logic [NUM_ENTRIES*24-1:0] INIT_TABLE = {
        {16'h3034, 8'h1A},
        {16'h3018, 8'hFF},
        {16'h3017, 8'hFF},
        {16'h3103, 8'h03},
        {16'h3008, 8'h42},
        {16'hFFFF, 8'd5},
        {16'h3008, 8'h82},
        {16'h3103, 8'h11}
    }
) (
    input  logic                      meg25,
    input  logic                      reset,
    input  logic                      start,
    ov5640_init_seq_if.master         i2c,
    output logic                      busy,
    output logic                      initial_done,
    output logic                      error,
    output logic [7:0]                step_index,
    output logic [1:0]                retry_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int DW = $clog2(255 * MS_CYCLES + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0] MS_W     = DW'(MS_CYCLES);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_ENTRIES - 1);
    localparam logic [1:0]    MAX_R    = 2'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_n;
    logic [23:0]   dat_q, dat_n;
    logic          sendit_q, sendit_n;
    logic [7:0]    step_q, step_n;
    logic [1:0]    retry_q, retry_n;
    logic [TW-1:0] tcnt_q, tcnt_n;
    logic [GW-1:0] gcnt_q, gcnt_n;
    logic [DW-1:0] dcnt_q, dcnt_n;
    logic          fail_q, fail_n;
    logic          pend_q, pend_n;
    logic [23:0]   cur_entry;

    // Table entry addressed by the current step.
    always_comb begin
        cur_entry = INIT_TABLE[24*int'(step_q) +: 24];
    end

    // State and datapath registers; reset overrides everything including start.
    always_ff @(posedge meg25) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dat_q    <= '0;
            sendit_q <= 1'b0;
            step_q   <= '0;
            retry_q  <= '0;
            tcnt_q   <= '0;
            gcnt_q   <= '0;
            dcnt_q   <= '0;
            fail_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            dat_q    <= dat_n;
            sendit_q <= sendit_n;
            step_q   <= step_n;
            retry_q  <= retry_n;
            tcnt_q   <= tcnt_n;
            gcnt_q   <= gcnt_n;
            dcnt_q   <= dcnt_n;
            fail_q   <= fail_n;
            pend_q   <= pend_n;
        end
    end

    // Next-state logic; the "advance" rule is shared by GAP expiry and DELAY expiry.
    always_comb begin
        state_n  = state_q;
        dat_n    = dat_q;
        sendit_n = sendit_q;
        step_n   = step_q;
        retry_n  = retry_q;
        tcnt_n   = tcnt_q;
        gcnt_n   = gcnt_q;
        dcnt_n   = dcnt_q;
        fail_n   = fail_q;
        pend_n   = pend_q;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_n = S_LOAD;
                    step_n  = '0;
                    retry_n = '0;
                    pend_n  = 1'b0;
                end
            end

            S_LOAD: begin
                if (cur_entry[23:8] == 16'hFFFF) begin
                    dcnt_n  = DW'(cur_entry[7:0]) * MS_W;
                    state_n = S_DELAY;
                end else begin
                    dat_n    = cur_entry;
                    sendit_n = 1'b1;
                    tcnt_n   = '0;
                    state_n  = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (!i2c.i2c_done) begin
                    tcnt_n  = '0;
                    state_n = S_WAIT_DONE;
                end else if (tcnt_q == TO_LAST) begin
                    sendit_n = 1'b0;
                    fail_n   = 1'b1;
                    state_n  = S_CHECK;
                end else begin
                    tcnt_n = tcnt_q + TW'(1);
                end
            end

            S_WAIT_DONE: begin
                if (i2c.i2c_done) begin
                    sendit_n = 1'b0;
                    fail_n   = i2c.i2c_ack;
                    state_n  = S_CHECK;
                end else if (tcnt_q == TO_LAST) begin
                    sendit_n = 1'b0;
                    fail_n   = 1'b1;
                    state_n  = S_CHECK;
                end else begin
                    tcnt_n = tcnt_q + TW'(1);
                end
            end

            S_CHECK: begin
                gcnt_n = '0;
                if (!fail_q) begin
                    pend_n  = 1'b0;
                    state_n = S_GAP;
                end else if (retry_q < MAX_R) begin
                    retry_n = retry_q + 2'd1;
                    pend_n  = 1'b1;
                    state_n = S_GAP;
                end else begin
                    state_n = S_FAIL;
                end
            end

            S_GAP, S_DELAY: begin
                if ((state_q == S_GAP   && gcnt_q != GAP_LAST) ||
                    (state_q == S_DELAY && dcnt_q != '0)) begin
                    gcnt_n = gcnt_q + GW'(1);
                    dcnt_n = (state_q == S_DELAY) ? dcnt_q - DW'(1) : dcnt_q;
                end else if (pend_q) begin
                    pend_n  = 1'b0;
                    state_n = S_LOAD;
                end else if (step_q == LAST_IDX) begin
                    state_n = S_DONE;
                end else begin
                    step_n  = step_q + 8'd1;
                    retry_n = '0;
                    state_n = S_LOAD;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    // Status decode and i2c outputs.
    always_comb begin
        busy              = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
        initial_done      = (state_q == S_DONE);
        error             = (state_q == S_FAIL);
        step_index        = step_q;
        retry_count       = retry_q;
        i2c.i2c_send_dat  = dat_q;
        i2c.i2c_sendit    = sendit_q;
    end

endmodule
